prefetch_ar_arbiter: RTL and testbench

Round-robin arbiter that shares one DDR-side AXI read channel (AR + R) between NUM_PORTS prefetcher controllers. It sits between the master AR/R ports of several prefetcher controllers and the DDR. It tags each issued request with the source port index in the upper ID bits, routes R beats back by that tag, and tracks per-port outstanding bursts. Prefetchers use the outstanding status as their has-outstanding indication during cleanup.

---
 rtl/prefetch_ar_arbiter.sv | 161 ++++++++++++++++
 tb/tb_prefetch_ar_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_ar_arbiter.sv
// Round-robin arbiter sharing one DDR AXI read channel between NUM_PORTS prefetchers.
// AR requests are tagged with the port index in the upper ID bits; R beats route back by that tag.
module prefetch_ar_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_BITS       = 64,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 64,
  parameter int OUTST_WIDTH     = 4,
  localparam int PORT_BITS      = $clog2(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic [NUM_PORTS-1:0]                 s_ar_valid,
  output logic [NUM_PORTS-1:0]                 s_ar_ready,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]       s_ar_addr,
  input  logic [NUM_PORTS*BURST_LEN_WIDTH-1:0] s_ar_len,
  input  logic [NUM_PORTS*TID_WIDTH-1:0]       s_ar_id,
  output logic [NUM_PORTS-1:0]                 s_r_valid,
  input  logic [NUM_PORTS-1:0]                 s_r_ready,
  output logic [TID_WIDTH-1:0]                 s_r_id,
  output logic [DATA_WIDTH-1:0]                s_r_data,
  output logic                                 s_r_last,
  output logic                                 m_ar_valid,
  input  logic                                 m_ar_ready,
  output logic [ADDR_BITS-1:0]                 m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]           m_ar_len,
  output logic [PORT_BITS+TID_WIDTH-1:0]       m_ar_id,
  input  logic                                 m_r_valid,
  output logic                                 m_r_ready,
  input  logic [PORT_BITS+TID_WIDTH-1:0]       m_r_id,
  input  logic [DATA_WIDTH-1:0]                m_r_data,
  input  logic                                 m_r_last,
  output logic [NUM_PORTS-1:0]                 port_busy,
  output logic                                 err_bad_id
);

  localparam int IDW = PORT_BITS + TID_WIDTH;
  localparam logic [OUTST_WIDTH-1:0] LIMIT     = '1;
  localparam logic [PORT_BITS:0]     NPORTS_W  = (PORT_BITS+1)'(NUM_PORTS);
  localparam logic [PORT_BITS-1:0]   LAST_PORT = PORT_BITS'(NUM_PORTS - 1);

  typedef enum logic {ST_ARB_IDLE, ST_ARB_ISSUE} state_t;

  state_t                                 state_q, state_d;
  logic [PORT_BITS-1:0]                   rr_q, rr_d;
  logic [ADDR_BITS-1:0]                   addr_q, addr_d;
  logic [BURST_LEN_WIDTH-1:0]             len_q, len_d;
  logic [IDW-1:0]                         id_q, id_d;
  logic [NUM_PORTS-1:0][OUTST_WIDTH-1:0]  cnt_q;
  logic [NUM_PORTS-1:0]                   busy_q;
  logic                                   err_q;

  logic [NUM_PORTS-1:0] elig, inc, dec;
  logic                 gnt_found;
  logic [PORT_BITS-1:0] gnt_idx, cand, iss_port, r_port;
  logic                 r_bad;

  assign iss_port = id_q[IDW-1 -: PORT_BITS];

  // Eligibility and round-robin search starting at rr_q
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = s_ar_valid[i] && (cnt_q[i] != LIMIT);
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PORT_BITS'((int'(rr_q) + k) % NUM_PORTS);
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    id_d       = id_q;
    s_ar_ready = '0;
    m_ar_valid = 1'b0;
    inc        = '0;
    case (state_q)
      ST_ARB_IDLE: begin
        if (en && gnt_found && !reset) begin
          s_ar_ready[gnt_idx] = 1'b1;
          addr_d  = s_ar_addr[gnt_idx*ADDR_BITS +: ADDR_BITS];
          len_d   = s_ar_len[gnt_idx*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
          id_d    = {gnt_idx, s_ar_id[gnt_idx*TID_WIDTH +: TID_WIDTH]};
          state_d = ST_ARB_ISSUE;
        end
      end
      ST_ARB_ISSUE: begin
        m_ar_valid = 1'b1;
        if (m_ar_ready) begin
          inc[iss_port] = 1'b1;
          rr_d    = (iss_port == LAST_PORT) ? '0 : iss_port + PORT_BITS'(1);
          state_d = ST_ARB_IDLE;
        end
      end
      default: state_d = ST_ARB_IDLE;
    endcase
  end

  // R routing: beats with an out-of-range port tag are drained and dropped
  always_comb begin
    r_port    = m_r_id[IDW-1 -: PORT_BITS];
    r_bad     = {1'b0, r_port} >= NPORTS_W;
    s_r_valid = '0;
    m_r_ready = 1'b1;
    dec       = '0;
    if (!r_bad) begin
      s_r_valid[r_port] = m_r_valid;
      m_r_ready         = s_r_ready[r_port];
      dec[r_port]       = m_r_valid && s_r_ready[r_port] && m_r_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARB_IDLE;
      rr_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        busy_q[i] <= (cnt_q[i] != '0);
        case ({inc[i], dec[i]})
          2'b10:   if (cnt_q[i] != LIMIT) cnt_q[i] <= cnt_q[i] + OUTST_WIDTH'(1);
          2'b01:   if (cnt_q[i] != '0)    cnt_q[i] <= cnt_q[i] - OUTST_WIDTH'(1);
          default: ;
        endcase
      end
      if (m_r_valid && r_bad) err_q <= 1'b1;
    end
  end

  assign m_ar_addr  = addr_q;
  assign m_ar_len   = len_q;
  assign m_ar_id    = id_q;
  assign s_r_id     = m_r_id[TID_WIDTH-1:0];
  assign s_r_data   = m_r_data;
  assign s_r_last   = m_r_last;
  assign port_busy  = busy_q;
  assign err_bad_id = err_q;

endmodule

// File: tb/tb_prefetch_ar_arbiter.sv
// Bench for prefetch_ar_arbiter: a 4-port instance checked against a transaction-level model
// every cycle, plus a 3-port instance for out-of-range R tags.
module tb_prefetch_ar_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en;

  // 4-port instance, OUTST_WIDTH = 2 (limit 3)
  logic [3:0]   s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, port_busy;
  logic [255:0] s_ar_addr;
  logic [31:0]  s_ar_len, s_ar_id;
  logic [7:0]   s_r_id, m_ar_len;
  logic [63:0]  s_r_data, m_ar_addr, m_r_data;
  logic         s_r_last, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last, err_bad_id;
  logic [9:0]   m_ar_id, m_r_id;

  prefetch_ar_arbiter #(.NUM_PORTS(4), .OUTST_WIDTH(2)) u4 (
    .clk(clk), .reset(reset), .en(en),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
    .s_r_data(s_r_data), .s_r_last(s_r_last),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id),
    .m_r_data(m_r_data), .m_r_last(m_r_last),
    .port_busy(port_busy), .err_bad_id(err_bad_id)
  );

  // 3-port instance: port tag 3 is out of range
  logic [2:0]   b_s_ar_valid, b_s_ar_ready, b_s_r_valid, b_s_r_ready, b_port_busy;
  logic [191:0] b_s_ar_addr;
  logic [23:0]  b_s_ar_len, b_s_ar_id;
  logic [7:0]   b_s_r_id, b_m_ar_len;
  logic [63:0]  b_s_r_data, b_m_ar_addr, b_m_r_data;
  logic         b_s_r_last, b_m_ar_valid, b_m_ar_ready, b_m_r_valid, b_m_r_ready, b_m_r_last, b_err;
  logic [9:0]   b_m_ar_id, b_m_r_id;

  prefetch_ar_arbiter #(.NUM_PORTS(3)) u3 (
    .clk(clk), .reset(reset), .en(en),
    .s_ar_valid(b_s_ar_valid), .s_ar_ready(b_s_ar_ready), .s_ar_addr(b_s_ar_addr),
    .s_ar_len(b_s_ar_len), .s_ar_id(b_s_ar_id),
    .s_r_valid(b_s_r_valid), .s_r_ready(b_s_r_ready), .s_r_id(b_s_r_id),
    .s_r_data(b_s_r_data), .s_r_last(b_s_r_last),
    .m_ar_valid(b_m_ar_valid), .m_ar_ready(b_m_ar_ready), .m_ar_addr(b_m_ar_addr),
    .m_ar_len(b_m_ar_len), .m_ar_id(b_m_ar_id),
    .m_r_valid(b_m_r_valid), .m_r_ready(b_m_r_ready), .m_r_id(b_m_r_id),
    .m_r_data(b_m_r_data), .m_r_last(b_m_r_last),
    .port_busy(b_port_busy), .err_bad_id(b_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model of the 4-port instance
  int          cnt_m [4];
  int          rr_m;
  bit          pend_m;
  logic [63:0] h_addr;
  logic [7:0]  h_len;
  logic [9:0]  h_id;
  logic [3:0]  busy_m;

  function automatic int exp_grant();
    if (reset || !en || pend_m) return -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (rr_m + k) % 4;
      if (s_ar_valid[idx] && cnt_m[idx] < 3) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    int pp;
    logic [1:0] p;
    bit fire;
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_m[i] = 0;
      rr_m = 0; pend_m = 1'b0;
      h_addr = '0; h_len = '0; h_id = '0; busy_m = '0;
    end else begin
      g    = exp_grant();
      p    = m_r_id[9:8];
      fire = m_r_valid && s_r_ready[p] && m_r_last;
      for (int i = 0; i < 4; i++) busy_m[i] = (cnt_m[i] != 0);
      if (pend_m && m_ar_ready) begin
        pp = int'(h_id[9:8]);
        cnt_m[pp] = cnt_m[pp] + 1;
        rr_m = (pp + 1) % 4;
        pend_m = 1'b0;
      end
      if (fire && cnt_m[p] > 0) cnt_m[p] = cnt_m[p] - 1;
      if (g >= 0) begin
        pend_m = 1'b1;
        h_addr = s_ar_addr[g*64 +: 64];
        h_len  = s_ar_len[g*8 +: 8];
        h_id   = {g[1:0], s_ar_id[g*8 +: 8]};
      end
    end
  end

  always @(negedge clk) begin : compare
    int g;
    logic [1:0] p;
    logic [3:0] er;
    if (chk_en) begin
      g  = exp_grant();
      er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      p  = m_r_id[9:8];
      chk("s_ar_ready", 128'(s_ar_ready), 128'(er));
      chk("m_ar_valid", 128'(m_ar_valid), 128'(pend_m));
      chk("m_ar_addr",  128'(m_ar_addr),  128'(h_addr));
      chk("m_ar_len",   128'(m_ar_len),   128'(h_len));
      chk("m_ar_id",    128'(m_ar_id),    128'(h_id));
      chk("s_r_valid",  128'(s_r_valid),  128'(m_r_valid ? (4'b0001 << p) : 4'b0000));
      chk("m_r_ready",  128'(m_r_ready),  128'(s_r_ready[p]));
      chk("s_r_id",     128'(s_r_id),     128'(m_r_id[7:0]));
      chk("s_r_data",   128'(s_r_data),   128'(m_r_data));
      chk("s_r_last",   128'(s_r_last),   128'(m_r_last));
      chk("port_busy",  128'(port_busy),  128'(busy_m));
      chk("err_bad_id", 128'(err_bad_id), 128'(1'b0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_req(input int port, input logic [63:0] a, input logic [7:0] l, input logic [7:0] id);
    s_ar_addr[port*64 +: 64] = a;
    s_ar_len[port*8 +: 8]    = l;
    s_ar_id[port*8 +: 8]     = id;
  endtask

  initial begin : stim
    logic [3:0] gv [5];
    int         gc [5];
    int         ng;
    int         beats;
    bit         hs;
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset = 1'b1; en = 1'b0;
    s_ar_valid = '0; s_ar_addr = '0; s_ar_len = '0; s_ar_id = '0; s_r_ready = '0;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_id = '0; m_r_data = '0; m_r_last = 1'b0;
    b_s_ar_valid = '0; b_s_ar_addr = '0; b_s_ar_len = '0; b_s_ar_id = '0; b_s_r_ready = '0;
    b_m_ar_ready = 1'b0; b_m_r_valid = 1'b0; b_m_r_id = '0; b_m_r_data = '0; b_m_r_last = 1'b0;
    step();
    chk_en = 1'b1;

    // Reset state: no grant while reset is high even with every port requesting
    en = 1'b1; s_ar_valid = 4'hf;
    #1;
    chk("rst_ar_ready", 128'(s_ar_ready), 128'(0));
    chk("rst_m_ar_valid", 128'(m_ar_valid), 128'(0));
    chk("rst_busy", 128'(port_busy), 128'(0));
    s_ar_valid = '0;
    step();
    reset = 1'b0;

    // Single request on port 2
    m_ar_ready = 1'b1;
    set_req(2, 64'hdeadbeef, 8'd4, 8'd3);
    s_ar_valid = 4'b0100;
    #1;
    chk("single_grant", 128'(s_ar_ready), 128'(4'b0100));
    step();
    s_ar_valid = '0;
    #1;
    chk("single_valid", 128'(m_ar_valid), 128'(1));
    chk("single_addr", 128'(m_ar_addr), 128'(64'hdeadbeef));
    chk("single_len", 128'(m_ar_len), 128'(8'd4));
    chk("single_id", 128'(m_ar_id), 128'(10'h203));
    step();
    step();
    chk("single_busy", 128'(port_busy), 128'(4'b0100));

    // R routing to port 2 with toggling ready
    beats = 0;
    m_r_valid = 1'b1; m_r_id = 10'h203;
    for (int c = 0; beats < 4 && c < 20; c++) begin
      m_r_last  = (beats == 3);
      m_r_data  = 64'h1000 + 64'(beats);
      s_r_ready = (c % 2 == 0) ? 4'b0100 : 4'b1011;
      #1;
      chk("r_valid", 128'(s_r_valid), 128'(4'b0100));
      chk("r_ready", 128'(m_r_ready), 128'(c % 2 == 0));
      chk("r_id", 128'(s_r_id), 128'(8'd3));
      hs = s_r_ready[2];
      step();
      if (hs) beats++;
    end
    chk("r_beats", 128'(beats), 128'(4));
    m_r_valid = 1'b0; m_r_last = 1'b0; s_r_ready = '0;
    step();
    chk("r_busy_clear", 128'(port_busy), 128'(0));

    // Round robin with all ports requesting
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 64'h1000 * 64'(i + 1), 8'(i + 1), 8'(i));
    s_ar_valid = 4'hf; m_ar_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (s_ar_ready != 4'b0000 && ng < 5) begin
        gv[ng] = s_ar_ready; gc[ng] = c; ng++;
      end
      step();
    end
    s_ar_valid = '0;
    chk("rr_count", 128'(ng), 128'(5));
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 128'(gv[k]), 128'(exp_g[k]));
      chk("rr_cycle", 128'(gc[k]), 128'(2 * k));
    end

    // Backpressure on the DDR AR channel
    do_reset();
    m_ar_ready = 1'b0;
    set_req(1, 64'h1234_5678_9abc_def0, 8'd7, 8'h55);
    s_ar_valid = 4'b0010;
    step();
    s_ar_valid = 4'hf;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", 128'(m_ar_valid), 128'(1));
      chk("bp_addr", 128'(m_ar_addr), 128'(64'h1234_5678_9abc_def0));
      chk("bp_id", 128'(m_ar_id), 128'(10'h155));
      chk("bp_no_grant", 128'(s_ar_ready), 128'(0));
      step();
    end
    m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0;
    #1;
    chk("bp_done", 128'(m_ar_valid), 128'(0));
    chk("bp_next_grant", 128'(s_ar_ready), 128'(4'b0100));
    s_ar_valid = '0;

    // Outstanding limit and same-edge increment/decrement on port 0
    do_reset();
    m_ar_ready = 1'b1;
    set_req(0, 64'h80, 8'd1, 8'h0a);
    set_req(1, 64'h90, 8'd2, 8'h0b);
    s_ar_valid = 4'b0001;
    for (int c = 0; c < 6; c++) step();
    #1;
    chk("lim_block0", 128'(s_ar_ready), 128'(0));
    step();
    chk("lim_block1", 128'(s_ar_ready), 128'(0));
    s_ar_valid = 4'b0011;
    #1;
    chk("lim_port1", 128'(s_ar_ready), 128'(4'b0010));
    step();
    s_ar_valid = 4'b0001;
    step();
    chk("lim_block2", 128'(s_ar_ready), 128'(0));
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_id = 10'h011; s_r_ready = 4'b0001;
    step();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    #1;
    chk("lim_release", 128'(s_ar_ready), 128'(4'b0001));
    step();
    m_r_valid = 1'b1; m_r_last = 1'b1;
    step();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    #1;
    chk("sim_still_elig", 128'(s_ar_ready), 128'(4'b0001));
    step();
    step();
    chk("sim_full_again", 128'(s_ar_ready), 128'(0));
    s_ar_valid = '0;

    // Reset while a request is waiting on the DDR
    m_ar_ready = 1'b0;
    set_req(3, 64'hfeed, 8'd9, 8'h77);
    s_ar_valid = 4'b1000;
    step();
    s_ar_valid = '0;
    #1;
    chk("rsti_pending", 128'(m_ar_valid), 128'(1));
    do_reset();
    #1;
    chk("rsti_valid", 128'(m_ar_valid), 128'(0));
    chk("rsti_addr", 128'(m_ar_addr), 128'(0));
    chk("rsti_id", 128'(m_ar_id), 128'(0));
    chk("rsti_busy", 128'(port_busy), 128'(0));
    step();
    chk("rsti_cnt_zero", 128'(port_busy), 128'(0));

    // Out-of-range port tag on the 3-port instance
    b_m_r_valid = 1'b1; b_m_r_id = 10'h107; b_s_r_ready = 3'b010; b_m_r_data = 64'habc;
    #1;
    chk("b_good_valid", 128'(b_s_r_valid), 128'(3'b010));
    chk("b_good_ready", 128'(b_m_r_ready), 128'(1));
    chk("b_good_id", 128'(b_s_r_id), 128'(8'h07));
    b_m_r_id = 10'h305; b_s_r_ready = 3'b000;
    #1;
    chk("b_bad_ready", 128'(b_m_r_ready), 128'(1));
    chk("b_bad_valid", 128'(b_s_r_valid), 128'(0));
    chk("b_err_before", 128'(b_err), 128'(0));
    step();
    b_m_r_valid = 1'b0;
    #1;
    chk("b_err_set", 128'(b_err), 128'(1));
    step();
    step();
    chk("b_err_sticky", 128'(b_err), 128'(1));
    do_reset();
    #1;
    chk("b_err_reset", 128'(b_err), 128'(0));

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
